lcd_line_composer: RTL and testbench

- Upstream stage of LCD_display. Turns a display request (message mode plus a 16-bit binary value) into the two 128-bit ASCII line buffers that LCD_display consumes on line1/line2.
- Converts the value to decimal with a sequential double-dabble engine.
- Formats both 16-character lines and signals completion with a one-cycle valid pulse.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_line_composer_bin2bcd.sv | 60 ++++++
 rtl/lcd_line_composer.sv | 124 ++++++++++++
 tb/tb_lcd_line_composer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, encodings and pre-packed ASCII literals for the LCD line composer.
// All line literals are packed column-0-low: column c occupies bits [8c+7:8c].
package lcd_pkg;

    localparam int LINE_W    = 128;
    localparam int COLS      = LINE_W / 8;
    localparam int DIGITS    = 5;
    localparam int BCD_W     = 4 * DIGITS;
    localparam int PFX_LEN   = 5;
    localparam int DIGIT_COL = PFX_LEN;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;

    typedef enum logic [1:0] {
        MODE_USER  = 2'd0,
        MODE_ADMIN = 2'd1,
        MODE_BAL   = 2'd2,
        MODE_ERR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_e;

    localparam logic [LINE_W-1:0] BLANK_LINE = {COLS{SPACE}};

    // "I am User", "I am Admin", "Balance", "Error", space-filled to 16 columns
    localparam logic [LINE_W-1:0] MSG_USER  = 128'h2020_2020_2020_2072_6573_5520_6d61_2049;
    localparam logic [LINE_W-1:0] MSG_ADMIN = 128'h2020_2020_2020_6e69_6d64_4120_6d61_2049;
    localparam logic [LINE_W-1:0] MSG_BAL   = 128'h2020_2020_2020_2020_2065_636e_616c_6142;
    localparam logic [LINE_W-1:0] MSG_ERR   = 128'h2020_2020_2020_2020_2020_2072_6f72_7245;

    // "VAL: " and "ERR: " line-2 prefixes
    localparam logic [8*PFX_LEN-1:0] PFX_VAL = 40'h20_3a4c_4156;
    localparam logic [8*PFX_LEN-1:0] PFX_ERR = 40'h20_3a52_5245;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/lcd_line_composer_bin2bcd.sv
// Sequential double-dabble converter: start loads the value, done is high during
// the last iteration, and bcd_o holds the final result from the following cycle.
module bin2bcd_seq
    import lcd_pkg::*;
#(
    parameter int VAL_W       = 16,
    parameter int CONV_CYCLES = VAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [VAL_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    localparam int CNT_W = $clog2(CONV_CYCLES);

    logic [VAL_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        // NOTE: every _d gets a hold default first, so no path can infer a latch.
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(CONV_CYCLES - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for all state so every register samples pre-edge values.
        if (!rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/lcd_line_composer.sv
// Turns a display request (mode + binary value) into the two 16-column ASCII line
// buffers for LCD_display, using a sequential BCD converter and a one-cycle valid pulse.
module lcd_line_composer
    import lcd_pkg::*;
#(
    parameter int VAL_W       = 16,
    parameter int CONV_CYCLES = VAL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [VAL_W-1:0]  value,
    output logic              busy,
    output logic              valid,
    output logic [LINE_W-1:0] line1,
    output logic [LINE_W-1:0] line2
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [LINE_W-1:0] line1_q, line1_d;
    logic [LINE_W-1:0] line2_q, line2_d;
    logic              accept;
    logic              conv_done;
    logic [BCD_W-1:0]  bcd;

    assign accept = (state_q == IDLE) && start;

    bin2bcd_seq #(
        .VAL_W       (VAL_W),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept),
        .bin_i   (value),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    function automatic logic [LINE_W-1:0] fmt_line1(input mode_e m);
        logic [LINE_W-1:0] l;
        case (m)
            MODE_USER:  l = MSG_USER;
            MODE_ADMIN: l = MSG_ADMIN;
            MODE_BAL:   l = MSG_BAL;
            default:    l = MSG_ERR;
        endcase
        return l;
    endfunction

    // Leading zeros stay blank until the first non-zero digit; the units digit always shows.
    function automatic logic [LINE_W-1:0] fmt_line2(input mode_e m, input logic [BCD_W-1:0] b);
        logic [LINE_W-1:0] l;
        logic [3:0]        nib;
        logic              lead;
        l = BLANK_LINE;
        l[8*PFX_LEN-1:0] = (m == MODE_ERR) ? PFX_ERR : PFX_VAL;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = b[4*d +: 4];
            if (nib != 4'd0 || d == 0) lead = 1'b0;
            if (!lead) l[8*(DIGIT_COL + DIGITS - 1 - d) +: 8] = ZERO + {4'h0, nib};
        end
        return l;
    endfunction

    // State register; line buffers reset to spaces so the display shows a blank screen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_USER;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            line1_q <= BLANK_LINE;
            line2_q <= BLANK_LINE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            line1_q <= line1_d;
            line2_q <= line2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = accept ? mode_e'(mode) : mode_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (conv_done) state_d = FORMAT;
            FORMAT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = busy_q;
        valid_d = 1'b0;
        line1_d = line1_q;
        line2_d = line2_q;
        case (state_q)
            IDLE:  busy_d = start;
            SHIFT: busy_d = 1'b1;
            FORMAT: begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                line1_d = fmt_line1(mode_q);
                line2_d = fmt_line2(mode_q, bcd);
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign line1 = line1_q;
    assign line2 = line2_q;

endmodule

// File: tb/tb_lcd_line_composer.sv
// Self-checking bench for lcd_line_composer: table vectors, hand-written timing
// sequences and random requests compared against a string-level reference model.
module tb_lcd_line_composer;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] v;
        string       l1;
        string       l2;
    } vec_t;

    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode  = 2'd0;
    logic [15:0]  value = 16'd0;
    logic         busy;
    logic         valid;
    logic [127:0] line1;
    logic [127:0] line2;

    int checks = 0;
    int errors = 0;

    lcd_line_composer #(
        .VAL_W       (16),
        .CONV_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .value (value),
        .busy  (busy),
        .valid (valid),
        .line1 (line1),
        .line2 (line2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1);
    end

    // Reference model: text built from the message rules, then packed column-0-low.
    function automatic logic [127:0] pack(input string s);
        logic [127:0] r;
        r = BLANK;
        for (int c = 0; c < 16 && c < s.len(); c++) r[8*c +: 8] = s[c];
        return r;
    endfunction

    function automatic string l1_text(input int m);
        string s;
        if (m == 0)      s = "I am User";
        else if (m == 1) s = "I am Admin";
        else if (m == 2) s = "Balance";
        else             s = "Error";
        return s;
    endfunction

    function automatic string l2_text(input int m, input int v);
        string p;
        if (m == 3) p = "ERR: ";
        else        p = "VAL: ";
        return {p, $sformatf("%5d", v)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(inout int n);
        do begin
            tick();
            n++;
        end while (!valid && n < 40);
    endtask

    // One full request from IDLE: accept, 17-edge latency, one-cycle valid, held lines.
    task automatic do_request(input logic [1:0] m, input logic [15:0] v,
                              input string e1, input string e2, input string tag);
        int lat;
        mode  = m;
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy after accept"}, 128'(busy), 128'd1);
        check({tag, " valid after accept"}, 128'(valid), 128'd0);
        lat = 0;
        wait_valid(lat);
        check({tag, " latency"}, 128'(lat), 128'd17);
        check({tag, " line1"}, line1, pack(e1));
        check({tag, " line2"}, line2, pack(e2));
        tick();
        check({tag, " valid drop"}, 128'(valid), 128'd0);
        check({tag, " busy idle"}, 128'(busy), 128'd0);
        check({tag, " line2 hold"}, line2, pack(e2));
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;
        int   pulses;
        logic [1:0]  rm;
        logic [15:0] rv;

        vecs[0] = '{2'd0, 16'd1234,  "I am User",  "VAL:  1234"};
        vecs[1] = '{2'd1, 16'd0,     "I am Admin", "VAL:     0"};
        vecs[2] = '{2'd3, 16'd65535, "Error",      "ERR: 65535"};
        vecs[3] = '{2'd2, 16'd42,    "Balance",    "VAL:    42"};
        vecs[4] = '{2'd2, 16'd10000, "Balance",    "VAL: 10000"};
        vecs[5] = '{2'd0, 16'd9,     "I am User",  "VAL:     9"};
        vecs[6] = '{2'd1, 16'd100,   "I am Admin", "VAL:   100"};

        // Reset held low for three edges, then released.
        rst = 1'b0;
        repeat (3) tick();
        check("reset line1", line1, BLANK);
        check("reset line2", line2, BLANK);
        check("reset busy", 128'(busy), 128'd0);
        check("reset valid", 128'(valid), 128'd0);
        rst = 1'b1;
        tick();
        check("post-reset line1", line1, BLANK);
        check("post-reset line2", line2, BLANK);
        check("post-reset busy", 128'(busy), 128'd0);

        foreach (vecs[i])
            do_request(vecs[i].m, vecs[i].v, vecs[i].l1, vecs[i].l2, $sformatf("vec%0d", i));

        // Start while busy is ignored; the next start right after valid is accepted.
        mode = 2'd0; value = 16'd1234; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (4) begin tick(); lat++; end
        mode = 2'd2; value = 16'd7; start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        check("ignore busy at k+5", 128'(busy), 128'd1);
        wait_valid(lat);
        check("ignore latency", 128'(lat), 128'd17);
        check("ignore line1", line1, pack("I am User"));
        check("ignore line2", line2, pack("VAL:  1234"));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("second accept busy", 128'(busy), 128'd1);
        check("second accept valid", 128'(valid), 128'd0);
        lat = 0;
        wait_valid(lat);
        check("second latency", 128'(lat), 128'd17);
        check("second line1", line1, pack("Balance"));
        check("second line2", line2, pack("VAL:     7"));
        tick();
        check("second valid drop", 128'(valid), 128'd0);

        // start held high: back-to-back results, input churn while busy is harmless.
        mode = 2'd2; value = 16'd42; start = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            lat = 0;
            do begin
                if (lat == 0)  begin mode = 2'd3; value = 16'($urandom); end
                if (lat == 10) begin mode = 2'd2; value = 16'd42; end
                tick();
                lat++;
            end while (!valid && lat < 40);
            check($sformatf("b2b%0d latency", p), 128'(lat), 128'd17);
            check($sformatf("b2b%0d line1", p), line1, pack("Balance"));
            check($sformatf("b2b%0d line2", p), line2, pack("VAL:    42"));
            if (p == 2) start = 1'b0;
            tick();
            check($sformatf("b2b%0d busy", p), 128'(busy), (p < 2) ? 128'd1 : 128'd0);
            check($sformatf("b2b%0d valid drop", p), 128'(valid), 128'd0);
        end

        // Reset in the middle of a conversion aborts it and blanks the lines.
        mode = 2'd1; value = 16'd321; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midrst busy before", 128'(busy), 128'd1);
        rst = 1'b0;
        tick();
        check("midrst line1", line1, BLANK);
        check("midrst line2", line2, BLANK);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst valid", 128'(valid), 128'd0);
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            if (valid || busy) pulses++;
        end
        check("midrst stays idle", 128'(pulses), 128'd0);
        do_request(2'd3, 16'd5, "Error", "ERR:     5", "after midrst");

        for (int i = 0; i < 20; i++) begin
            rm = 2'($urandom_range(0, 3));
            rv = 16'($urandom_range(0, 65535));
            do_request(rm, rv, l1_text(int'(rm)), l2_text(int'(rm), int'(rv)),
                       $sformatf("rand%0d m=%0d v=%0d", i, rm, rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
